ternary_matvec: RTL and testbench

Compute stage downstream of the weight loader. It takes the loader's flattened 2-bit ternary weight bus and a stream of signed 8-bit activations, and accumulates one dot product per output column in parallel. When the vector is complete, it drains the results one byte per cycle. It is the datapath core between the weight loader and the chip's output pins.

---
 rtl/ternary_pkg.sv | 30 +++
 rtl/ternary_mac.sv | 42 ++++
 rtl/ternary_matvec.sv | 125 ++++++++++++
 tb/tb_ternary_matvec.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary matrix-vector datapath: weight codes,
// FSM states, ui_param field layout and the saturating output formatter.
package ternary_pkg;

    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;
    localparam logic [1:0] W_ZERO = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    localparam int OUT_LEN_LSB = 0;
    localparam int OUT_LEN_W   = 3;
    localparam int IN_LEN_LSB  = 3;
    localparam int IN_LEN_W    = 4;

    // Clamp a sign-extended accumulator to the signed byte range.
    function automatic logic [7:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127)
            return 8'h7F;
        else if (v < -32'sd128)
            return 8'h80;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/ternary_mac.sv
// One output column: ternary select (+x, -x, 0) feeding a signed accumulator
// that is overwritten by the first sample of a vector and summed afterwards.
module ternary_mac
    import ternary_pkg::*;
#(
    parameter int ACC_W = 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    add,
    input  logic signed [7:0]       x,
    input  logic        [1:0]       w,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] term;

    assign x_ext = ACC_W'(x);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        term = '0;
        case (w)
            W_POS:   term = x_ext;
            W_NEG:   term = -x_ext;
            W_ZERO:  term = '0;
            default: term = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (load)
            acc <= term;
        else if (add)
            acc <= acc + term;
    end

endmodule

// File: rtl/ternary_matvec.sv
// Ternary matrix-vector core: accumulates one dot product per column, then drains
// one result byte per cycle. Define TERNARY_SATURATE_EN to saturate instead of wrap.
module ternary_matvec
    import ternary_pkg::*;
#(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int ACC_W       = 8 + $clog2(MAX_IN_LEN) + 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ena,
    input  logic [7:0]                         ui_input,
    input  logic [6:0]                         ui_param,
    input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] ui_weights,
    input  logic                               ui_load_done,
    output logic [7:0]                         uo_output,
    output logic                               uo_valid,
    output logic                               uo_busy
);

    state_t                  state, state_next;
    logic                    wready;
    logic [IN_LEN_W-1:0]     in_idx, in_len_m1, row;
    logic [OUT_LEN_W-1:0]    out_idx, out_len_m1;
    logic                    load, add;
    logic [1:0]              w_row [MAX_OUT_LEN];
    logic signed [ACC_W-1:0] acc   [MAX_OUT_LEN];
    logic signed [ACC_W-1:0] acc_sel;
    logic [7:0]              fmt_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        add        = 1'b0;
        case (state)
            IDLE: if (ena && wready) begin
                load       = 1'b1;
                state_next = (ui_param[IN_LEN_LSB +: IN_LEN_W] == '0) ? DRAIN : ACCUM;
            end
            ACCUM: if (ena) begin
                add = 1'b1;
                if (in_idx == in_len_m1)
                    state_next = DRAIN;
            end
            DRAIN: if (out_idx == out_len_m1)
                state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Row 0 feeds the first sample taken in IDLE; later rows follow in_idx.
    assign row = (state == IDLE) ? '0 : in_idx;

    always_comb begin
        for (int j = 0; j < MAX_OUT_LEN; j++)
            w_row[j] = ui_weights[2*(int'(row)*MAX_OUT_LEN + j) +: 2];
    end

    for (genvar j = 0; j < MAX_OUT_LEN; j++) begin : g_col
        ternary_mac #(.ACC_W(ACC_W)) u_mac (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load),
            .add   (add),
            .x     (ui_input),
            .w     (w_row[j]),
            .acc   (acc[j])
        );
    end

    assign acc_sel = acc[out_idx];

`ifdef TERNARY_SATURATE_EN
    assign fmt_byte = sat8(32'(acc_sel));
`else
    assign fmt_byte = acc_sel[7:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wready     <= 1'b0;
            in_idx     <= '0;
            in_len_m1  <= '0;
            out_idx    <= '0;
            out_len_m1 <= '0;
            uo_output  <= '0;
            uo_valid   <= 1'b0;
        end else begin
            if (ui_load_done)
                wready <= 1'b1;

            if (load) begin
                in_len_m1  <= ui_param[IN_LEN_LSB +: IN_LEN_W];
                out_len_m1 <= ui_param[OUT_LEN_LSB +: OUT_LEN_W];
                in_idx     <= IN_LEN_W'(1);
                out_idx    <= '0;
            end else if (add) begin
                in_idx  <= in_idx + IN_LEN_W'(1);
                out_idx <= '0;
            end else if (state == DRAIN) begin
                out_idx <= out_idx + OUT_LEN_W'(1);
            end

            // Output register shows a result only while draining, zero otherwise.
            if (state == DRAIN) begin
                uo_output <= fmt_byte;
                uo_valid  <= 1'b1;
            end else begin
                uo_output <= '0;
                uo_valid  <= 1'b0;
            end
        end
    end

    assign uo_busy = (state != IDLE);

endmodule

// File: tb/tb_ternary_matvec.sv
// Directed and randomized bench for ternary_matvec; results are predicted from
// plain dot-product arithmetic over a weight table kept in the bench.
module tb_ternary_matvec;

    localparam int NI = 16;
    localparam int NO = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               ena = 1'b0;
    logic [7:0]         ui_input = '0;
    logic [6:0]         ui_param = '0;
    logic [2*NI*NO-1:0] ui_weights = '0;
    logic               ui_load_done = 1'b0;
    logic [7:0]         uo_output;
    logic               uo_valid;
    logic               uo_busy;

    int         vectors = 0;
    int         miscompares = 0;
    logic [1:0] wcode [NI][NO];
    int         xs [NI];
    int         exp_sum [NO];

    ternary_matvec #(.MAX_IN_LEN(NI), .MAX_OUT_LEN(NO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .ui_input     (ui_input),
        .ui_param     (ui_param),
        .ui_weights   (ui_weights),
        .ui_load_done (ui_load_done),
        .uo_output    (uo_output),
        .uo_valid     (uo_valid),
        .uo_busy      (uo_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int wval(input logic [1:0] c);
        if (c == 2'b01) return 1;
        if (c == 2'b11) return -1;
        return 0;
    endfunction

    function automatic logic [7:0] fmt_model(input int s);
`ifdef TERNARY_SATURATE_EN
        if (s > 127) return 8'h7F;
        if (s < -128) return 8'h80;
`endif
        return s[7:0];
    endfunction

    function automatic void compute_expected(input int in_len);
        for (int j = 0; j < NO; j++) begin
            exp_sum[j] = 0;
            for (int i = 0; i < in_len; i++)
                exp_sum[j] += wval(wcode[i][j]) * xs[i];
        end
    endfunction

    task automatic drive_weights();
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < NO; j++)
                ui_weights[2*(i*NO+j) +: 2] = wcode[i][j];
    endtask

    task automatic load_weights();
        drive_weights();
        @(negedge clk); ui_load_done = 1'b1;
        @(negedge clk); ui_load_done = 1'b0;
    endtask

    task automatic random_weights();
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < NO; j++)
                wcode[i][j] = 2'($urandom);
    endtask

    task automatic random_samples();
        byte b;
        for (int k = 0; k < NI; k++) begin
            b = byte'($urandom);
            xs[k] = b;
        end
    endtask

    // Present in_len samples; returns at the negedge after the last accepting edge.
    task automatic feed(input int in_len, input int out_len, input bit gaps);
        ui_param = 7'(((in_len - 1) << 3) | (out_len - 1));
        for (int k = 0; k < in_len; k++) begin
            if (gaps && k > 0)
                repeat ($urandom_range(0, 2)) begin
                    ena = 1'b0; ui_input = 8'($urandom);
                    @(negedge clk);
                end
            ena = 1'b1; ui_input = 8'(xs[k]);
            @(negedge clk);
            if (gaps && k == 0) ui_param = 7'($urandom);
        end
        ena = 1'b0;
    endtask

    task automatic drain(input int out_len, input bit junk, input bit tail);
        check("valid_before_drain", 32'(uo_valid), 32'd0);
        check("busy_in_drain", 32'(uo_busy), 32'd1);
        for (int m = 1; m <= out_len; m++) begin
            if (junk) begin ena = 1'b1; ui_input = 8'($urandom); end
            @(negedge clk);
            check($sformatf("valid_col%0d", m-1), 32'(uo_valid), 32'd1);
            check($sformatf("out_col%0d", m-1), 32'(uo_output), 32'(fmt_model(exp_sum[m-1])));
        end
        ena = 1'b0;
        if (tail) begin
            @(negedge clk);
            check("valid_after_drain", 32'(uo_valid), 32'd0);
            check("busy_after_drain", 32'(uo_busy), 32'd0);
            check("output_idle_zero", 32'(uo_output), 32'd0);
        end
    endtask

    task automatic run_vector(input int in_len, input int out_len, input bit gaps, input bit junk);
        compute_expected(in_len);
        feed(in_len, out_len, gaps);
        drain(out_len, junk, 1'b1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #3;
        check("reset_output", 32'(uo_output), 32'd0);
        check("reset_valid", 32'(uo_valid), 32'd0);
        check("reset_busy", 32'(uo_busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Samples before and during the load pulse are ignored.
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < NO; j++)
                wcode[i][j] = 2'b01;
        drive_weights();
        repeat (3) begin
            ena = 1'b1; ui_input = 8'($urandom);
            @(negedge clk);
            check("busy_before_load", 32'(uo_busy), 32'd0);
        end
        ui_load_done = 1'b1;
        @(negedge clk);
        check("busy_on_load_cycle", 32'(uo_busy), 32'd0);
        ui_load_done = 1'b0; ena = 1'b0;
        @(negedge clk);

        // All +1, samples 1..4, two columns.
        for (int k = 0; k < 4; k++) xs[k] = k + 1;
        run_vector(4, 2, 1'b0, 1'b0);

        // Column 0 all -1, column 1 all 0, samples 5 x4.
        for (int i = 0; i < NI; i++) begin
            wcode[i][0] = 2'b11;
            wcode[i][1] = 2'b00;
        end
        load_weights();
        for (int k = 0; k < 4; k++) xs[k] = 5;
        run_vector(4, 2, 1'b0, 1'b0);

        // Full-length vector of 127 with all +1: sum 2032.
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < NO; j++)
                wcode[i][j] = 2'b01;
        load_weights();
        for (int k = 0; k < NI; k++) xs[k] = 127;
        run_vector(16, 1, 1'b0, 1'b0);

        // Random vectors with ena gaps, mid-run ui_param changes and drain-time junk.
        repeat (6) begin
            random_weights();
            load_weights();
            random_samples();
            run_vector($urandom_range(1, NI), $urandom_range(1, NO), 1'b1, 1'b1);
        end

        // Reset mid-drain after the first of four outputs.
        random_weights();
        load_weights();
        random_samples();
        compute_expected(4);
        feed(4, 4, 1'b0);
        check("abort_valid_before", 32'(uo_valid), 32'd0);
        @(negedge clk);
        check("abort_first_valid", 32'(uo_valid), 32'd1);
        check("abort_first_out", 32'(uo_output), 32'(fmt_model(exp_sum[0])));
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid_drop", 32'(uo_valid), 32'd0);
        check("abort_busy_drop", 32'(uo_busy), 32'd0);
        check("abort_output_zero", 32'(uo_output), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            ena = 1'b1; ui_input = 8'($urandom);
            @(negedge clk);
            check("abort_no_output", 32'(uo_valid), 32'd0);
            check("abort_needs_reload", 32'(uo_busy), 32'd0);
        end
        ena = 1'b0;
        load_weights();
        random_samples();
        run_vector(4, 4, 1'b0, 1'b0);

        // in_len = 1 with a reserved code in column 3, then a back-to-back vector.
        for (int j = 0; j < NO; j++) wcode[0][j] = 2'b01;
        wcode[0][3] = 2'b10;
        load_weights();
        xs[0] = -7;
        compute_expected(1);
        feed(1, 8, 1'b0);
        drain(8, 1'b0, 1'b0);
        random_samples();
        run_vector($urandom_range(2, NI), $urandom_range(1, NO), 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
